// File: rtl/hazard_ctrl_if.sv
// Stall/flush control bundle between the core datapath and hazard_ctrl.
// The slave side is the sequencer; the master side is the pipeline that consumes the controls.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             lu_hazard_rs1_i;
    logic             lu_hazard_rs2_i;
    logic             redirect_i;
    logic             imem_ready_i;
    logic             mem_access_i;
    logic             dmem_ready_i;
    logic             pc_en_o;
    logic             if_id_en_o;
    logic             if_id_flush_o;
    logic             id_ex_en_o;
    logic             id_ex_flush_o;
    logic             ex_mem_en_o;
    logic             mem_wb_en_o;
    logic             mem_wb_flush_o;
    logic             flush_active_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] dmem_stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  lu_hazard_rs1_i, lu_hazard_rs2_i, redirect_i, imem_ready_i, mem_access_i,
               dmem_ready_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o,
               mem_wb_en_o, mem_wb_flush_o, flush_active_o, lu_stall_cnt_o, dmem_stall_cnt_o,
               flush_cnt_o
    );

    modport master (
        output lu_hazard_rs1_i, lu_hazard_rs2_i, redirect_i, imem_ready_i, mem_access_i,
               dmem_ready_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o,
               mem_wb_en_o, mem_wb_flush_o, flush_active_o, lu_stall_cnt_o, dmem_stall_cnt_o,
               flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with a post-redirect IF/ID flush window.
// Define HAZARD_CTRL_PERF_CNT_EN to enable the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic {StRun, StFlush} state_e;

    localparam logic [3:0] ReloadCnt = 4'(FLUSH_CYCLES - 1);

    state_e     state_q;
    logic [3:0] cnt_q;

    logic dwait, redir_hit, flush_hit, lu_hit, imiss_hit;

    // Priority-masked rule flags: exactly one (or none) is set per cycle.
    assign dwait     = hz.mem_access_i & ~hz.dmem_ready_i;
    assign redir_hit = ~dwait & hz.redirect_i;
    assign flush_hit = ~dwait & ~hz.redirect_i & (state_q == StFlush);
    assign lu_hit    = ~dwait & ~hz.redirect_i & (state_q != StFlush)
                       & (hz.lu_hazard_rs1_i | hz.lu_hazard_rs2_i);
    assign imiss_hit = ~dwait & ~hz.redirect_i & (state_q != StFlush)
                       & ~(hz.lu_hazard_rs1_i | hz.lu_hazard_rs2_i) & ~hz.imem_ready_i;

    always_comb begin
        if (!rst_ni) begin
            hz.pc_en_o        = 1'b0;
            hz.if_id_en_o     = 1'b0;
            hz.if_id_flush_o  = 1'b1;
            hz.id_ex_en_o     = 1'b0;
            hz.id_ex_flush_o  = 1'b1;
            hz.ex_mem_en_o    = 1'b0;
            hz.mem_wb_en_o    = 1'b0;
            hz.mem_wb_flush_o = 1'b1;
            hz.flush_active_o = 1'b0;
        end else begin
            hz.pc_en_o        = ~dwait & ~lu_hit & ~imiss_hit;
            hz.if_id_en_o     = ~dwait & ~lu_hit;
            hz.if_id_flush_o  = redir_hit | flush_hit | imiss_hit;
            hz.id_ex_en_o     = ~dwait;
            hz.id_ex_flush_o  = redir_hit | lu_hit;
            hz.ex_mem_en_o    = ~dwait;
            hz.mem_wb_en_o    = ~dwait;
            hz.mem_wb_flush_o = dwait;
            hz.flush_active_o = (state_q == StFlush);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else if (redir_hit) begin
            if (FLUSH_CYCLES > 1) begin
                state_q <= StFlush;
                cnt_q   <= ReloadCnt;
            end else begin
                state_q <= StRun;
                cnt_q   <= 4'd0;
            end
        end else if (flush_hit) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_q <= StRun;
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, dm_cnt_q, fl_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lu_cnt_q <= '0;
            dm_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (lu_hit && !(&lu_cnt_q)) lu_cnt_q <= lu_cnt_q + 1'b1;
            if (dwait && !(&dm_cnt_q)) dm_cnt_q <= dm_cnt_q + 1'b1;
            if ((redir_hit || flush_hit) && !(&fl_cnt_q)) fl_cnt_q <= fl_cnt_q + 1'b1;
        end
    end

    assign hz.lu_stall_cnt_o   = lu_cnt_q;
    assign hz.dmem_stall_cnt_o = dm_cnt_q;
    assign hz.flush_cnt_o      = fl_cnt_q;
`else
    assign hz.lu_stall_cnt_o   = '0;
    assign hz.dmem_stall_cnt_o = '0;
    assign hz.flush_cnt_o      = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a rule-level model queues expected outputs per cycle and a
// negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
    localparam int unsigned FC  = 3;
    localparam int unsigned CW  = 4;
    localparam int          Sat = (1 << CW) - 1;

    typedef struct packed {
        logic [8:0]    ctl;
        logic [CW-1:0] lu;
        logic [CW-1:0] dm;
        logic [CW-1:0] fl;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .hz    (hz)
    );

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   flush_left = 0;  // FLUSH cycles still owed after the current one
    int   c_lu = 0, c_dm = 0, c_fl = 0;

    function automatic logic [8:0] pk(input bit pc, ifen, iffl, idexen, idexfl, exmem, mwen,
                                      mwfl, fa);
        return {pc, ifen, iffl, idexen, idexfl, exmem, mwen, mwfl, fa};
    endfunction

    function automatic logic [CW-1:0] cnt_exp(input int v);
`ifdef HAZARD_CTRL_PERF_CNT_EN
        return v[CW-1:0];
`else
        return (v < 0) ? '1 : '0;
`endif
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= Sat) ? Sat : v + 1;
    endfunction

    task automatic apply(input bit rst, input bit r1, input bit r2, input bit red,
                         input bit imem, input bit macc, input bit dmr);
        obs_t e;
        bit   fa;
        rst_n              = rst;
        hz.lu_hazard_rs1_i = r1;
        hz.lu_hazard_rs2_i = r2;
        hz.redirect_i      = red;
        hz.imem_ready_i    = imem;
        hz.mem_access_i    = macc;
        hz.dmem_ready_i    = dmr;
        if (!rst) begin
            flush_left = 0;
            c_lu = 0; c_dm = 0; c_fl = 0;
        end
        e.lu = cnt_exp(c_lu);
        e.dm = cnt_exp(c_dm);
        e.fl = cnt_exp(c_fl);
        fa   = flush_left > 0;
        if (!rst) begin
            e.ctl = pk(0, 0, 1, 0, 1, 0, 0, 1, 0);
        end else if (macc && !dmr) begin
            e.ctl = pk(0, 0, 0, 0, 0, 0, 0, 1, fa);
            c_dm  = sat_inc(c_dm);
        end else if (red) begin
            e.ctl = pk(1, 1, 1, 1, 1, 1, 1, 0, fa);
            flush_left = FC - 1;
            c_fl  = sat_inc(c_fl);
        end else if (flush_left > 0) begin
            e.ctl = pk(1, 1, 1, 1, 0, 1, 1, 0, fa);
            flush_left--;
            c_fl  = sat_inc(c_fl);
        end else if (r1 || r2) begin
            e.ctl = pk(0, 0, 0, 1, 1, 1, 1, 0, fa);
            c_lu  = sat_inc(c_lu);
        end else if (!imem) begin
            e.ctl = pk(0, 1, 1, 1, 0, 1, 1, 0, fa);
        end else begin
            e.ctl = pk(1, 1, 0, 1, 0, 1, 1, 0, fa);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 1, 0, 0);
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.ctl = {hz.pc_en_o, hz.if_id_en_o, hz.if_id_flush_o, hz.id_ex_en_o,
                     hz.id_ex_flush_o, hz.ex_mem_en_o, hz.mem_wb_en_o, hz.mem_wb_flush_o,
                     hz.flush_active_o};
            a.lu = hz.lu_stall_cnt_o;
            a.dm = hz.dmem_stall_cnt_o;
            a.fl = hz.flush_cnt_o;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got ctl=%b lu=%0d dm=%0d fl=%0d, expected ctl=%b lu=%0d dm=%0d fl=%0d",
                         cyc, a.ctl, a.lu, a.dm, a.fl, e.ctl, e.lu, e.dm, e.fl);
            end
        end
    end

    initial begin
        hz.lu_hazard_rs1_i = 1'b0;
        hz.lu_hazard_rs2_i = 1'b0;
        hz.redirect_i      = 1'b0;
        hz.imem_ready_i    = 1'b1;
        hz.mem_access_i    = 1'b0;
        hz.dmem_ready_i    = 1'b0;
        @(posedge clk);
        #1;
        apply(0, 0, 0, 0, 1, 0, 0);          // reset state
        apply(0, 1, 1, 1, 0, 1, 0);          // reset overrides every input
        idle(2);
        apply(1, 1, 0, 0, 1, 0, 0);          // single load-use bubble
        idle(2);
        apply(1, 0, 0, 1, 1, 0, 0);          // redirect opens 3-cycle flush window
        idle(4);
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 1, 1, 1, 0);  // dwait freezes redirect
        apply(1, 0, 0, 1, 1, 1, 1);          // redirect taken once memory completes
        idle(4);
        apply(1, 0, 1, 0, 0, 0, 0);          // load-use + imem miss: IF/ID holds
        apply(1, 0, 0, 0, 0, 0, 0);          // imem miss alone: bubble into ID
        idle(1);
        apply(1, 0, 0, 1, 1, 0, 0);          // redirect
        apply(1, 0, 0, 1, 1, 0, 0);          // redirect in 2nd flush cycle reloads
        apply(1, 1, 0, 0, 1, 0, 0);          // load-use ignored in FLUSH
        idle(3);
        apply(1, 0, 0, 1, 1, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0);          // reset mid-FLUSH
        idle(2);
        for (int i = 0; i < 20; i++) apply(1, 0, 0, 0, 1, 1, 0);  // saturate dwait counter
        idle(2);
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(99) != 0), ($urandom_range(99) < 12), ($urandom_range(99) < 8),
                  ($urandom_range(99) < 10), ($urandom_range(99) < 80),
                  ($urandom_range(99) < 30), ($urandom_range(99) < 60));
        end
        idle(1);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
